axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 Parameter DATA_WIDTH, default 64, AXI and SRAM data width (bytes per beat = DATA_WIDTH/8).
REQ-003 Parameter ID_WIDTH, default 4, AXI ID width.
REQ-004 Parameter DEPTH_LOG, default 16, SRAM word-address width.
REQ-005 clk  input  1  single clock; every flop is rising-edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 AXI4 slave AW/W/B/AR/R channels  in/out  standard widths  carry the CPU core's AxiIO master traffic; no user, lock, cache, prot, qos, or region handling.
REQ-008 sram_en  output  1  SRAM access this cycle.
REQ-009 sram_we  output  1  write when 1, read when 0.
REQ-010 sram_addr  output  DEPTH_LOG  word index.
REQ-011 sram_wdata/sram_wstrb  output  DATA_WIDTH/(DATA_WIDTH/8)  write data and byte enables.
REQ-012 sram_rdata  input  DATA_WIDTH  read data, valid exactly 1 cycle after a read enable.

Function
REQ-013 The FSM SHALL use states IDLE, WRITE, WRESP, READ; only one burst is active at any time.
REQ-014 In IDLE with only awvalid or only arvalid set, that channel SHALL be granted; with both set, grant SHALL alternate, starting with write.
REQ-015 Grant: awready or arready pulses high for one cycle; ID, addr, len, size, and burst are latched; the beat counter is cleared.
REQ-016 Word index SHALL be addr[log2(bytes)+DEPTH_LOG-1 : log2(bytes)]; higher bits are ignored, so accesses alias modulo the SRAM size.
REQ-017 Address update per beat: FIXED keeps it; INCR adds 1<<size; WRAP adds 1<<size and wraps within an aligned window of (len+1)<<size bytes. Reserved burst type 2'b11 is treated as INCR.
REQ-018 WRITE: wready=1; each W handshake drives sram_en=1, sram_we=1, with wstrb passed through unmodified in the same cycle.
REQ-019 WRITE exits to WRESP after beat len+1; the beat counter governs and wlast does not.
REQ-020 bresp SHALL be OKAY (2'b00) if wlast was set only on the final beat, else SLVERR (2'b10). bid equals the latched awid.
REQ-021 WRESP: bvalid=1 and held until bready; the cycle after the handshake the FSM is in IDLE.
REQ-022 READ: SRAM reads are issued back-to-back into a 2-entry R FIFO; a read is issued only when (FIFO occupancy + reads in flight) < 2.
REQ-023 R: rvalid = FIFO non-empty; rid = latched arid; rresp = OKAY; rlast set on beat len+1.
REQ-024 READ returns to IDLE on the rlast handshake.
REQ-025 Throughput: sustained 1 R beat per cycle with rready=1; first R beat 2 cycles after the AR handshake.
REQ-026 rvalid, rdata, and rlast SHALL be stable while rready=0; bvalid and bid/bresp SHALL be stable while bready=0.
REQ-027 len=0 bursts are single-beat; len=255 is supported, with a 9-bit beat counter and no overflow.
REQ-028 In the same cycle the FSM is never in both WRITE and READ, so sram_we never conflicts with an outstanding read.

Reset
REQ-029 While rst=0: state=IDLE; awready, wready, arready, bvalid, rvalid, sram_en, sram_we = 0; R FIFO emptied; arbitration favours write; all counters 0.
REQ-030 Reset asserted mid-burst SHALL abort the burst with no further SRAM access; pending responses are discarded.
REQ-031 The first grant is possible in the first rising edge after rst deasserts.

Verification
REQ-032 Write INCR, awaddr=0x100, len=3, size=3, data 0x11..0x44, wlast on beat 4 -> SRAM words 0x20..0x23 written; bresp=OKAY, bid=awid.
REQ-033 Read of the same region with rready=1 -> rdata 0x11,0x22,0x33,0x44 on consecutive cycles, rlast on the 4th beat, first beat 2 cycles after AR.
REQ-034 Read WRAP, araddr=0x118, len=3, size=3 -> word sequence 0x23,0x20,0x21,0x22.
REQ-035 awvalid and arvalid raised together twice -> grant order write, read, write, read; no SRAM write occurs while a read is in flight.
REQ-036 Read with len=7 and rready toggling 1,0,0,1,... -> no beat lost or duplicated; FIFO never exceeds 2 entries; R payload held while stalled.
REQ-037 Write with wlast on beat 2 of len=3 -> 4 SRAM writes, bresp=SLVERR; rst pulsed low during beat 2 of a second write -> no further sram_en, and all outputs return to reset values.

Source files
------------

// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
//
// This module bridges an AXI4 slave port to a single-port synchronous SRAM.
// Only one burst is active at a time. A four-state FSM (IDLE, WRITE, WRESP,
// READ) sequences the bursts. When AW and AR requests arrive together, the
// grant alternates between them, starting with write.
//
// Ports
//   clk_i, rst_ni        clock (rising edge) and asynchronous active-low reset
//   aw*_i / awready_o    write address channel (id, addr, len, size, burst)
//   w*_i  / wready_o     write data channel (data, strobes, last)
//   b*_o  / bready_i     write response channel (id, resp)
//   ar*_i / arready_o    read address channel (id, addr, len, size, burst)
//   r*_o  / rready_i     read data channel (id, data, resp, last)
//   sram_en_o            SRAM access this cycle
//   sram_we_o            1 = write, 0 = read
//   sram_addr_o          SRAM word index
//   sram_wdata_o         SRAM write data
//   sram_wstrb_o         SRAM byte enables
//   sram_rdata_i         SRAM read data, valid one cycle after a read enable
// -----------------------------------------------------------------------------
module axi_sram_slave #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 4,
   parameter int DEPTH_LOG  = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [ID_WIDTH-1:0]     awid_i,
   input  logic [ADDR_WIDTH-1:0]   awaddr_i,
   input  logic [7:0]              awlen_i,
   input  logic [2:0]              awsize_i,
   input  logic [1:0]              awburst_i,
   input  logic                    awvalid_i,
   output logic                    awready_o,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH/8-1:0] wstrb_i,
   input  logic                    wlast_i,
   input  logic                    wvalid_i,
   output logic                    wready_o,
   output logic [ID_WIDTH-1:0]     bid_o,
   output logic [1:0]              bresp_o,
   output logic                    bvalid_o,
   input  logic                    bready_i,
   input  logic [ID_WIDTH-1:0]     arid_i,
   input  logic [ADDR_WIDTH-1:0]   araddr_i,
   input  logic [7:0]              arlen_i,
   input  logic [2:0]              arsize_i,
   input  logic [1:0]              arburst_i,
   input  logic                    arvalid_i,
   output logic                    arready_o,
   output logic [ID_WIDTH-1:0]     rid_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic [1:0]              rresp_o,
   output logic                    rlast_o,
   output logic                    rvalid_o,
   input  logic                    rready_i,
   output logic                    sram_en_o,
   output logic                    sram_we_o,
   output logic [DEPTH_LOG-1:0]    sram_addr_o,
   output logic [DATA_WIDTH-1:0]   sram_wdata_o,
   output logic [DATA_WIDTH/8-1:0] sram_wstrb_o,
   input  logic [DATA_WIDTH-1:0]   sram_rdata_i
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int OFFSET     = $clog2(STRB_WIDTH);

   typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_e;

   state_e                  state_q;
   logic [ID_WIDTH-1:0]     id_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [7:0]              len_q;
   logic [2:0]              size_q;
   logic [1:0]              burst_q;
   logic [8:0]              beat_q;
   logic [8:0]              issued_q;
   logic                    preferWrite_q;
   logic                    wlastErr_q;
   logic                    inflight_q;
   logic [DATA_WIDTH-1:0]   fifo_q [2];
   logic                    wrPtr_q;
   logic                    rdPtr_q;
   logic [1:0]              count_q;

   logic                    grantWrite;
   logic                    grantRead;
   logic                    writeFire;
   logic                    rFire;
   logic                    lastBeat;
   logic                    readIssue;
   logic [2:0]              occupancy;
   logic [ADDR_WIDTH-1:0]   addr_d;

   // Compute the address of the next beat. A WRAP burst stays inside an
   // aligned window of (len+1) << size bytes. The reserved burst type is
   // treated like INCR.
   function automatic logic [ADDR_WIDTH-1:0] nextAddr(
      input logic [ADDR_WIDTH-1:0] addr,
      input logic [7:0]            len,
      input logic [2:0]            size,
      input logic [1:0]            burst
   );
      logic [ADDR_WIDTH-1:0] step;
      logic [ADDR_WIDTH-1:0] sum;
      logic [ADDR_WIDTH-1:0] wrapMask;
      step     = ADDR_WIDTH'(1) << size;
      sum      = addr + step;
      wrapMask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
      case (burst)
         2'b00:   nextAddr = addr;
         2'b10:   nextAddr = (addr & ~wrapMask) | (sum & wrapMask);
         default: nextAddr = sum;
      endcase
   endfunction

   // Grants are decoded directly from the IDLE state, so the ready signal
   // pulses high for the single cycle in which the handshake completes.
   // The reset term keeps both ready signals low while the reset is held.
   assign grantWrite = rst_ni && (state_q == IDLE) && awvalid_i && (!arvalid_i || preferWrite_q);
   assign grantRead  = rst_ni && (state_q == IDLE) && arvalid_i && !grantWrite;
   assign awready_o  = grantWrite;
   assign arready_o  = grantRead;

   assign wready_o   = (state_q == WRITE);
   assign writeFire  = wready_o && wvalid_i;
   assign lastBeat   = (beat_q == {1'b0, len_q});

   assign bvalid_o   = (state_q == WRESP);
   assign bid_o      = id_q;
   assign bresp_o    = wlastErr_q ? 2'b10 : 2'b00;

   assign rvalid_o   = (count_q != 2'd0);
   assign rFire      = rvalid_o && rready_i;
   assign rid_o      = id_q;
   assign rdata_o    = fifo_q[rdPtr_q];
   assign rresp_o    = 2'b00;
   assign rlast_o    = lastBeat;

   // The occupancy count includes the slot freed by a pop in this cycle.
   // This lets a new read issue every cycle while rready stays high, and
   // the FIFO plus the in-flight read still never exceed two entries.
   assign occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, rFire};
   assign readIssue  = (state_q == READ) && (issued_q <= {1'b0, len_q}) && (occupancy < 3'd2);

   assign addr_d       = nextAddr(addr_q, len_q, size_q, burst_q);
   assign sram_en_o    = writeFire || readIssue;
   assign sram_we_o    = writeFire;
   assign sram_addr_o  = addr_q[OFFSET +: DEPTH_LOG];
   assign sram_wdata_o = wdata_i;
   assign sram_wstrb_o = wstrb_i;

   // This block holds the burst FSM together with its address and beat
   // bookkeeping and the two-entry R FIFO. A reset aborts any burst that is
   // in progress and discards any response that is still pending.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         id_q          <= '0;
         addr_q        <= '0;
         len_q         <= '0;
         size_q        <= '0;
         burst_q       <= '0;
         beat_q        <= '0;
         issued_q      <= '0;
         preferWrite_q <= 1'b1;
         wlastErr_q    <= 1'b0;
         inflight_q    <= 1'b0;
         fifo_q[0]     <= '0;
         fifo_q[1]     <= '0;
         wrPtr_q       <= 1'b0;
         rdPtr_q       <= 1'b0;
         count_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grantWrite) begin
                  id_q          <= awid_i;
                  addr_q        <= awaddr_i;
                  len_q         <= awlen_i;
                  size_q        <= awsize_i;
                  burst_q       <= awburst_i;
                  beat_q        <= '0;
                  wlastErr_q    <= 1'b0;
                  preferWrite_q <= 1'b0;
                  state_q       <= WRITE;
               end else if (grantRead) begin
                  id_q          <= arid_i;
                  addr_q        <= araddr_i;
                  len_q         <= arlen_i;
                  size_q        <= arsize_i;
                  burst_q       <= arburst_i;
                  beat_q        <= '0;
                  issued_q      <= '0;
                  inflight_q    <= 1'b0;
                  wrPtr_q       <= 1'b0;
                  rdPtr_q       <= 1'b0;
                  count_q       <= '0;
                  preferWrite_q <= 1'b1;
                  state_q       <= READ;
               end
            end
            WRITE: begin
               // The beat counter ends the burst. A wlast on the wrong beat,
               // or a missing wlast, only marks the response as SLVERR.
               if (writeFire) begin
                  addr_q <= addr_d;
                  beat_q <= beat_q + 9'd1;
                  if (wlast_i != lastBeat) begin
                     wlastErr_q <= 1'b1;
                  end
                  if (lastBeat) begin
                     state_q <= WRESP;
                  end
               end
            end
            WRESP: begin
               if (bready_i) begin
                  state_q <= IDLE;
               end
            end
            READ: begin
               inflight_q <= readIssue;
               if (readIssue) begin
                  addr_q   <= addr_d;
                  issued_q <= issued_q + 9'd1;
               end
               if (inflight_q) begin
                  fifo_q[wrPtr_q] <= sram_rdata_i;
                  wrPtr_q         <= ~wrPtr_q;
               end
               if (rFire) begin
                  rdPtr_q <= ~rdPtr_q;
                  beat_q  <= beat_q + 9'd1;
                  if (lastBeat) begin
                     state_q <= IDLE;
                  end
               end
               count_q <= count_q + {1'b0, inflight_q} - {1'b0, rFire};
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_sram_slave
//
// Directed testbench for axi_sram_slave. It contains a behavioural SRAM with
// a one-cycle read latency. It drives directed AXI bursts and compares the
// responses and SRAM contents against hand-computed values.
// -----------------------------------------------------------------------------
module tb_axi_sram_slave;

   localparam logic [1:0] FIXED = 2'b00;
   localparam logic [1:0] INCR  = 2'b01;
   localparam logic [1:0] WRAP  = 2'b10;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic [3:0]  awid = '0;
   logic [31:0] awaddr = '0;
   logic [7:0]  awlen = '0;
   logic [2:0]  awsize = '0;
   logic [1:0]  awburst = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [63:0] wdata = '0;
   logic [7:0]  wstrb = '0;
   logic        wlast = 1'b0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [3:0]  arid = '0;
   logic [31:0] araddr = '0;
   logic [7:0]  arlen = '0;
   logic [2:0]  arsize = '0;
   logic [1:0]  arburst = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [3:0]  rid;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready = 1'b0;
   logic        sramEn;
   logic        sramWe;
   logic [15:0] sramAddr;
   logic [63:0] sramWdata;
   logic [7:0]  sramWstrb;
   logic [63:0] sramRdata = '0;

   logic [63:0] mem [0:65535];
   logic [63:0] wData [16];
   logic [7:0]  wStrb [16];
   logic [63:0] expR [16];
   logic [3:0]  expId;

   int checks = 0;
   int errors = 0;
   int sramWrites = 0;
   int sramReads = 0;
   int sramEnCount = 0;
   int rBeats = 0;
   int maxOut = 0;
   int conflicts = 0;
   bit readBusy = 1'b0;

   axi_sram_slave dut (
      .clk_i        (clk),
      .rst_ni       (rstN),
      .awid_i       (awid),
      .awaddr_i     (awaddr),
      .awlen_i      (awlen),
      .awsize_i     (awsize),
      .awburst_i    (awburst),
      .awvalid_i    (awvalid),
      .awready_o    (awready),
      .wdata_i      (wdata),
      .wstrb_i      (wstrb),
      .wlast_i      (wlast),
      .wvalid_i     (wvalid),
      .wready_o     (wready),
      .bid_o        (bid),
      .bresp_o      (bresp),
      .bvalid_o     (bvalid),
      .bready_i     (bready),
      .arid_i       (arid),
      .araddr_i     (araddr),
      .arlen_i      (arlen),
      .arsize_i     (arsize),
      .arburst_i    (arburst),
      .arvalid_i    (arvalid),
      .arready_o    (arready),
      .rid_o        (rid),
      .rdata_o      (rdata),
      .rresp_o      (rresp),
      .rlast_o      (rlast),
      .rvalid_o     (rvalid),
      .rready_i     (rready),
      .sram_en_o    (sramEn),
      .sram_we_o    (sramWe),
      .sram_addr_o  (sramAddr),
      .sram_wdata_o (sramWdata),
      .sram_wstrb_o (sramWstrb),
      .sram_rdata_i (sramRdata)
   );

   // Free-running clock with a 10-time-unit period.
   always #5 clk = ~clk;

   // The SRAM model and traffic monitor. It counts SRAM accesses and R
   // beats, and it flags any SRAM write that occurs while a read burst is
   // still in progress.
   always @(posedge clk) begin
      if (sramEn) begin
         sramEnCount++;
         if (sramWe) begin
            for (int b = 0; b < 8; b++) begin
               if (sramWstrb[b]) mem[sramAddr][8*b +: 8] = sramWdata[8*b +: 8];
            end
            sramWrites++;
            if (readBusy) conflicts++;
         end else begin
            sramRdata <= mem[sramAddr];
            sramReads++;
         end
      end
      if (rvalid && rready) rBeats++;
      if (arvalid && arready) readBusy = 1'b1;
      if (rvalid && rready && rlast) readBusy = 1'b0;
      if (!rstN) readBusy = 1'b0;
      if (sramReads - rBeats > maxOut) maxOut = sramReads - rBeats;
   end

   // Watchdog that ends the run if the directed sequence stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   // Each call performs one compare, counts it, and reports the failure if
   // the values differ.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Present an AW request and wait, with a bound, for the grant.
   task automatic sendAw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
      bit granted = 1'b0;
      awid = id; awaddr = addr; awlen = len; awsize = 3'd3; awburst = burst; awvalid = 1'b1;
      for (int i = 0; i < 40 && !granted; i++) begin
         #1;
         if (awready) granted = 1'b1;
         else @(negedge clk);
      end
      checkOutput("aw_grant", 64'(granted), 64'd1);
      @(negedge clk);
      awvalid = 1'b0;
   endtask

   // Present an AR request and wait, with a bound, for the grant.
   task automatic sendAr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
      bit granted = 1'b0;
      arid = id; araddr = addr; arlen = len; arsize = 3'd3; arburst = burst; arvalid = 1'b1;
      for (int i = 0; i < 40 && !granted; i++) begin
         #1;
         if (arready) granted = 1'b1;
         else @(negedge clk);
      end
      checkOutput("ar_grant", 64'(granted), 64'd1);
      @(negedge clk);
      arvalid = 1'b0;
   endtask

   // Send the W beats of a burst. wlast is asserted on beat lastAt.
   task automatic sendW(input int len, input int lastAt);
      for (int i = 0; i <= len; i++) begin
         bit ready = 1'b0;
         wdata = wData[i]; wstrb = wStrb[i]; wlast = (i == lastAt); wvalid = 1'b1;
         for (int g = 0; g < 40 && !ready; g++) begin
            #1;
            if (wready) ready = 1'b1;
            else @(negedge clk);
         end
         checkOutput("w_ready", 64'(ready), 64'd1);
         @(negedge clk);
      end
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   // Wait for the B response. Hold bready low for 'stall' cycles while
   // checking that the response stays stable, then accept it.
   task automatic getB(input int stall, output logic [1:0] resp, output logic [3:0] id);
      bit seen = 1'b0;
      bready = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         #1;
         if (bvalid) seen = 1'b1;
         else @(negedge clk);
      end
      checkOutput("b_valid", 64'(seen), 64'd1);
      resp = bresp; id = bid;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk); #1;
         checkOutput("b_hold", 64'({bvalid, bid, bresp}), 64'({1'b1, id, resp}));
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      #1;
      checkOutput("b_done", 64'(bvalid), 64'd0);
   endtask

   // Collect R beats against expR and expId. In toggle mode rready follows
   // the pattern 1,0,0,1. While a beat is stalled its payload must not change.
   task automatic getR(input int len, input bit toggle, output int cyc);
      int beat = 0;
      bit held = 1'b0;
      logic [63:0] heldData = '0;
      logic heldLast = 1'b0;
      cyc = 0;
      while (beat <= len && cyc < 200) begin
         rready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         #1;
         if (held) begin
            checkOutput("r_hold_valid", 64'(rvalid), 64'd1);
            checkOutput("r_hold_data", rdata, heldData);
            checkOutput("r_hold_last", 64'(rlast), 64'(heldLast));
         end
         if (rvalid) begin
            if (rready) begin
               checkOutput("r_data", rdata, expR[beat]);
               checkOutput("r_last", 64'(rlast), 64'(beat == len));
               checkOutput("r_id_resp", 64'({rid, rresp}), 64'({expId, 2'b00}));
               beat++;
               held = 1'b0;
            end else begin
               held = 1'b1; heldData = rdata; heldLast = rlast;
            end
         end
         @(negedge clk);
         cyc++;
      end
      rready = 1'b0;
      checkOutput("r_beats", 64'(beat), 64'(len + 1));
      #1;
      checkOutput("r_drained", 64'(rvalid), 64'd0);
   endtask

   // Run the directed sequence from reset through each burst scenario.
   initial begin
      logic [1:0] resp;
      logic [3:0] id;
      int cyc;
      int snap;

      repeat (3) @(negedge clk);
      checkOutput("reset_outputs", 64'({awready, wready, arready, bvalid, rvalid, sramEn, sramWe}), 64'd0);
      rstN = 1'b1;

      // INCR write of four beats to 0x100, which covers words 0x20..0x23.
      wData[0] = 64'h11; wData[1] = 64'h22; wData[2] = 64'h33; wData[3] = 64'h44;
      for (int i = 0; i < 16; i++) wStrb[i] = 8'hFF;
      sendAw(4'h5, 32'h100, 8'd3, INCR);
      sendW(3, 3);
      getB(0, resp, id);
      checkOutput("wr1_bresp", 64'(resp), 64'd0);
      checkOutput("wr1_bid", 64'(id), 64'h5);
      checkOutput("wr1_mem20", mem[16'h20], 64'h11);
      checkOutput("wr1_mem21", mem[16'h21], 64'h22);
      checkOutput("wr1_mem22", mem[16'h22], 64'h33);
      checkOutput("wr1_mem23", mem[16'h23], 64'h44);
      checkOutput("wr1_count", 64'(sramWrites), 64'd4);

      // Read back the same region. The first beat arrives two cycles after
      // the AR handshake, and the following beats arrive on consecutive cycles.
      expR[0] = 64'h11; expR[1] = 64'h22; expR[2] = 64'h33; expR[3] = 64'h44;
      expId = 4'h9;
      rready = 1'b1;
      sendAr(4'h9, 32'h100, 8'd3, INCR);
      checkOutput("rd1_lat1", 64'(rvalid), 64'd0);
      @(negedge clk);
      checkOutput("rd1_lat2", 64'(rvalid), 64'd0);
      @(negedge clk);
      checkOutput("rd1_lat3", 64'(rvalid), 64'd1);
      getR(3, 1'b0, cyc);
      checkOutput("rd1_cycles", 64'(cyc), 64'd4);

      // WRAP read starting at 0x118. The word order is 0x23, 0x20, 0x21, 0x22.
      expR[0] = 64'h44; expR[1] = 64'h11; expR[2] = 64'h22; expR[3] = 64'h33;
      expId = 4'hA;
      sendAr(4'hA, 32'h118, 8'd3, WRAP);
      getR(3, 1'b0, cyc);

      // FIXED write of two beats. The second beat updates only the low bytes.
      wData[0] = 64'h1111_2222_3333_4444; wStrb[0] = 8'hFF;
      wData[1] = 64'hAAAA_BBBB_CCCC_DDDD; wStrb[1] = 8'h0F;
      sendAw(4'h1, 32'h300, 8'd1, FIXED);
      sendW(1, 1);
      getB(0, resp, id);
      checkOutput("fix_bresp", 64'(resp), 64'd0);
      checkOutput("fix_mem60", mem[16'h60], 64'h1111_2222_CCCC_DDDD);
      wStrb[0] = 8'hFF; wStrb[1] = 8'hFF;

      // Eight-beat write, then a read with rready toggling.
      for (int i = 0; i < 8; i++) begin
         wData[i] = 64'h1000 + 64'(i);
         expR[i] = 64'h1000 + 64'(i);
      end
      sendAw(4'h2, 32'h200, 8'd7, INCR);
      sendW(7, 7);
      getB(0, resp, id);
      checkOutput("wr8_bresp", 64'(resp), 64'd0);
      maxOut = 0;
      expId = 4'h3;
      sendAr(4'h3, 32'h200, 8'd7, INCR);
      getR(7, 1'b1, cyc);
      checkOutput("fifo_depth", 64'(maxOut), 64'd2);

      // Simultaneous AW and AR, round one. Write is granted first, then read.
      conflicts = 0;
      wData[0] = 64'hDEAD;
      arid = 4'h6; araddr = 32'h100; arlen = 8'd0; arsize = 3'd3; arburst = INCR; arvalid = 1'b1;
      awid = 4'h7; awaddr = 32'h500; awlen = 8'd0; awsize = 3'd3; awburst = INCR; awvalid = 1'b1;
      #1;
      checkOutput("arb1_aw", 64'(awready), 64'd1);
      checkOutput("arb1_ar", 64'(arready), 64'd0);
      sendAw(4'h7, 32'h500, 8'd0, INCR);
      sendW(0, 0);
      getB(0, resp, id);
      checkOutput("arb1_bid", 64'(id), 64'h7);
      expR[0] = 64'h11; expId = 4'h6;
      sendAr(4'h6, 32'h100, 8'd0, INCR);
      getR(0, 1'b0, cyc);

      // Simultaneous AW and AR, round two. The read fetches word 0xA0,
      // which round one wrote.
      wData[0] = 64'hBEEF;
      arid = 4'h4; araddr = 32'h500; arlen = 8'd0; arsize = 3'd3; arburst = INCR; arvalid = 1'b1;
      awid = 4'hB; awaddr = 32'h508; awlen = 8'd0; awsize = 3'd3; awburst = INCR; awvalid = 1'b1;
      #1;
      checkOutput("arb2_aw", 64'(awready), 64'd1);
      checkOutput("arb2_ar", 64'(arready), 64'd0);
      sendAw(4'hB, 32'h508, 8'd0, INCR);
      sendW(0, 0);
      getB(0, resp, id);
      checkOutput("arb2_mema1", mem[16'hA1], 64'hBEEF);
      expR[0] = 64'hDEAD; expId = 4'h4;
      sendAr(4'h4, 32'h500, 8'd0, INCR);
      getR(0, 1'b0, cyc);
      checkOutput("arb_conflicts", 64'(conflicts), 64'd0);

      // wlast arrives early, on beat 2 of 4. All four beats are still
      // written, and the response is SLVERR.
      for (int i = 0; i < 4; i++) wData[i] = 64'h5000 + 64'(i);
      snap = sramWrites;
      sendAw(4'h8, 32'h600, 8'd3, INCR);
      sendW(3, 1);
      getB(3, resp, id);
      checkOutput("err_bresp", 64'(resp), 64'h2);
      checkOutput("err_bid", 64'(id), 64'h8);
      checkOutput("err_count", 64'(sramWrites - snap), 64'd4);

      // Reset pulse during beat 2 of a write. No further SRAM access may
      // occur, and all outputs must return to their reset values.
      sendAw(4'hC, 32'h700, 8'd3, INCR);
      wdata = 64'h7000; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
      #1;
      checkOutput("rst_beat1_ready", 64'(wready), 64'd1);
      @(negedge clk);
      snap = sramEnCount;
      wdata = 64'h7001;
      #1;
      rstN = 1'b0;
      #1;
      checkOutput("rst_no_en", 64'(sramEn), 64'd0);
      @(negedge clk);
      wvalid = 1'b0;
      @(negedge clk);
      rstN = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst_en_count", 64'(sramEnCount), 64'(snap));
      checkOutput("rst_outputs", 64'({awready, wready, arready, bvalid, rvalid, sramEn, sramWe}), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
